// File: rtl/led_blink_monitor.sv
// Blink receiver: synchronizes led_in, measures toggle intervals, counts edges, flags a stuck input.
// Edges land 2 cycles after s1 samples (4 with `BLINK_MON_GLITCH_FILTER_EN, which adds a 3-sample agreement filter).
module led_blink_monitor #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             led_in,
  output logic             led_level,
  output logic [CNT_W-1:0] half_period,
  output logic             period_valid,
  output logic [7:0]       edge_count,
  output logic             stuck
);

  typedef enum logic [1:0] {
    WAIT_EDGE = 2'd0,
    MEASURE   = 2'd1,
    STUCK     = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             led_level_q, led_level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] half_period_q, half_period_d;
  logic             period_valid_q, period_valid_d;
  logic [7:0]       edge_count_q, edge_count_d;
  logic             cand;
  logic             edge_acc;

`ifdef BLINK_MON_GLITCH_FILTER_EN
  // s2 plus two history stages form the 3-sample window; the level moves only on unanimity.
  logic [1:0] flt_q, flt_d;

  always_comb begin
    flt_d = {flt_q[0], s2_q};
    cand  = led_level_q;
    if ((s2_q == flt_q[0]) && (s2_q == flt_q[1])) begin
      cand = s2_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flt_q <= 2'b00;
    end else begin
      flt_q <= flt_d;
    end
  end
`else
  always_comb begin
    cand = s2_q;
  end
`endif

  assign s1_d     = led_in;
  assign s2_d     = s1_q;
  assign edge_acc = (cand != led_level_q);

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    led_level_d    = led_level_q;
    half_period_d  = half_period_q;
    period_valid_d = 1'b0;
    edge_count_d   = edge_count_q;

    if (edge_acc) begin
      led_level_d  = cand;
      edge_count_d = edge_count_q + 8'd1;
      cnt_d        = '0;
      state_d      = MEASURE;
      // Only an interval bounded by two real edges is a valid measurement.
      if (state_q == MEASURE) begin
        half_period_d  = cnt_q + CNT_W'(1);
        period_valid_d = 1'b1;
      end
    end else begin
      case (state_q)
        STUCK: begin
          cnt_d = '0;
        end
        default: begin
          if (cnt_q == CNT_MAX) begin
            state_d = STUCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= WAIT_EDGE;
      s1_q           <= 1'b0;
      s2_q           <= 1'b0;
      led_level_q    <= 1'b0;
      cnt_q          <= '0;
      half_period_q  <= '0;
      period_valid_q <= 1'b0;
      edge_count_q   <= 8'd0;
    end else begin
      state_q        <= state_d;
      s1_q           <= s1_d;
      s2_q           <= s2_d;
      led_level_q    <= led_level_d;
      cnt_q          <= cnt_d;
      half_period_q  <= half_period_d;
      period_valid_q <= period_valid_d;
      edge_count_q   <= edge_count_d;
    end
  end

  assign led_level    = led_level_q;
  assign half_period  = half_period_q;
  assign period_valid = period_valid_q;
  assign edge_count   = edge_count_q;
  assign stuck        = (state_q == STUCK);

endmodule
